// File: rtl/nibble_accum_pkg.sv
// Shared types and widths for the nibble sum accumulator.
package nibble_accum_pkg;

  localparam int SUM_W = 8;  // 16 * 15 = 240 always fits, so the sum never wraps
  localparam int NIB_W = 4;
  localparam int CNT_W = 5;  // must be able to hold a count of 16

  localparam logic [NIB_W-1:0] MIN_INIT = 4'hF;
  localparam logic [NIB_W-1:0] MAX_INIT = 4'h0;

  typedef enum logic [1:0] {
    ACCUM      = 2'd0,
    EMIT_SUM   = 2'd1,
    EMIT_STATS = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_stats.sv
// Running statistics for one batch: sum, sample count, max and min nibble.
// Re-initialisation takes priority over loading a new sample.
module nibble_stats
  import nibble_accum_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_init,
  input  logic             i_load,
  input  logic [NIB_W-1:0] i_data,
  output logic [SUM_W-1:0] o_sum,
  output logic [CNT_W-1:0] o_cnt,
  output logic [NIB_W-1:0] o_max,
  output logic [NIB_W-1:0] o_min
);

  logic [SUM_W-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic [NIB_W-1:0] r_max;
  logic [NIB_W-1:0] r_min;

  // Statistics registers: clear on reset/init, fold in one sample per load.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      r_sum <= '0;
      r_cnt <= '0;
      r_max <= MAX_INIT;
      r_min <= MIN_INIT;
    end else if (i_init) begin
      r_sum <= '0;
      r_cnt <= '0;
      r_max <= MAX_INIT;
      r_min <= MIN_INIT;
    end else if (i_load) begin
      r_sum <= r_sum + SUM_W'(i_data);
      r_cnt <= r_cnt + CNT_W'(1);
      if (i_data > r_max) r_max <= i_data;
      if (i_data < r_min) r_min <= i_data;
    end
  end

  assign o_sum = r_sum;
  assign o_cnt = r_cnt;
  assign o_max = r_max;
  assign o_min = r_min;

endmodule

// File: rtl/nibble_sum_accum.sv
// Accumulates BATCH 4-bit sums, then emits a two-byte record:
// the 8-bit sum (out_last=0) followed by {max,min} (out_last=1).
module nibble_sum_accum
  import nibble_accum_pkg::*;
#(
  parameter int BATCH = 8  // legal range 1..16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [NIB_W-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [SUM_W-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy
);

  // Count value seen just before the sample that completes the batch.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BATCH - 1);

  state_t r_state;
  state_t w_state_next;

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_batch_done;
  logic             w_stats_init;
  logic             w_stats_load;
  logic [SUM_W-1:0] w_sum;
  logic [CNT_W-1:0] w_cnt;
  logic [NIB_W-1:0] w_max;
  logic [NIB_W-1:0] w_min;

  assign w_in_xfer    = in_valid && in_ready;
  assign w_out_xfer   = out_valid && out_ready;
  assign w_batch_done = w_in_xfer && (w_cnt == LAST_CNT);

  // A new batch starts after the stats byte drains or on an abort.
  assign w_stats_init = clear || ((r_state == EMIT_STATS) && w_out_xfer);
  assign w_stats_load = w_in_xfer && !clear;

  nibble_stats u_stats (
    .clk    (clk),
    .reset  (reset),
    .i_init (w_stats_init),
    .i_load (w_stats_load),
    .i_data (in_data),
    .o_sum  (w_sum),
    .o_cnt  (w_cnt),
    .o_max  (w_max),
    .o_min  (w_min)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ACCUM;
    else       r_state <= w_state_next;
  end

  // Next-state logic and output mux; outputs depend on state only.
  always_comb begin
    // NOTE: every output gets a default first so no path can leave one
    // unassigned, which would otherwise infer a latch.
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    out_data     = '0;

    unique case (r_state)
      ACCUM: begin
        in_ready = 1'b1;
        if (w_batch_done) w_state_next = EMIT_SUM;
      end
      EMIT_SUM: begin
        out_valid = 1'b1;
        out_data  = w_sum;
        if (w_out_xfer) w_state_next = EMIT_STATS;
      end
      EMIT_STATS: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = {w_max, w_min};
        if (w_out_xfer) w_state_next = ACCUM;
      end
      default: w_state_next = ACCUM;
    endcase

    // Abort wins over any transfer; a pending output byte is dropped.
    if (clear) w_state_next = ACCUM;
  end

  assign busy = (w_cnt != '0) || (r_state != ACCUM);

endmodule

// File: tb/tb_nibble_sum_accum.sv
// Bench for nibble_sum_accum: four instances (BATCH = 1, 2, 4, 16) share clk
// and reset. A batch-level model predicts every output each cycle; directed
// scenarios additionally pin the emitted bytes to hand-computed literals.
module tb_nibble_sum_accum;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear     [4];
  logic       in_valid  [4];
  logic [3:0] in_data   [4];
  logic       in_ready  [4];
  logic       out_valid [4];
  logic [7:0] out_data  [4];
  logic       out_last  [4];
  logic       out_ready [4];
  logic       busy      [4];

  always #5 clk = ~clk;

  function automatic int batch_of(int k);
    case (k)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      default: return 16;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int BV = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
    nibble_sum_accum #(.BATCH(BV)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear[g]),
      .in_valid  (in_valid[g]),
      .in_data   (in_data[g]),
      .in_ready  (in_ready[g]),
      .out_valid (out_valid[g]),
      .out_data  (out_data[g]),
      .out_last  (out_last[g]),
      .out_ready (out_ready[g]),
      .busy      (busy[g])
    );
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- batch-level model ----------------
  // pend = output bytes still owed for the current record (0 = collecting).
  int         pend [4];
  int         ns   [4];
  logic [3:0] samp [4][16];

  function automatic logic [7:0] m_sum(int k);
    int s = 0;
    for (int i = 0; i < ns[k]; i++) s += int'(samp[k][i]);
    return 8'(s);
  endfunction

  function automatic logic [7:0] m_stats(int k);
    int mx = 0;
    int mn = 15;
    for (int i = 0; i < ns[k]; i++) begin
      if (int'(samp[k][i]) > mx) mx = int'(samp[k][i]);
      if (int'(samp[k][i]) < mn) mn = int'(samp[k][i]);
    end
    return {4'(mx), 4'(mn)};
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 4; k++) begin
      if (reset || clear[k]) begin
        pend[k] <= 0;
        ns[k]   <= 0;
      end else if (pend[k] == 0) begin
        if (in_valid[k] && ns[k] < 16) begin
          samp[k][ns[k]] <= in_data[k];
          ns[k]          <= ns[k] + 1;
          if (ns[k] + 1 == batch_of(k)) pend[k] <= 2;
        end
      end else if (out_ready[k]) begin
        pend[k] <= pend[k] - 1;
        if (pend[k] == 1) ns[k] <= 0;
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      check($sformatf("in_ready[%0d]", k), 32'(in_ready[k]), 32'(pend[k] == 0));
      check($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(pend[k] != 0));
      check($sformatf("out_last[%0d]", k), 32'(out_last[k]), 32'(pend[k] == 1));
      check($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(ns[k] != 0 || pend[k] != 0));
      if (pend[k] == 2) check($sformatf("sum_byte[%0d]", k), 32'(out_data[k]), 32'(m_sum(k)));
      if (pend[k] == 1) check($sformatf("stats_byte[%0d]", k), 32'(out_data[k]), 32'(m_stats(k)));
      if (reset) check($sformatf("reset_data[%0d]", k), 32'(out_data[k]), 32'h0);
    end
  end

  // Record every byte that will transfer on the coming edge.
  logic [10:0] cap [$];
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++)
      if (!reset && !clear[k] && out_valid[k] && out_ready[k])
        cap.push_back({2'(k), out_last[k], out_data[k]});
  end

  // Cycles with in_ready low on the BATCH=2 instance.
  int ir_low = 0;
  always @(negedge clk) if (!reset && !in_ready[1]) ir_low <= ir_low + 1;

  // ---------------- stimulus helpers ----------------
  task automatic wait_cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(int k, logic [3:0] d);
    bit acc = 1'b0;
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready[k];
      @(posedge clk);
      #1;
    end
    check($sformatf("send_accept[%0d]", k), 32'(acc), 32'h1);
  endtask

  task automatic expect_byte(int k, logic l, logic [7:0] d);
    logic [10:0] e;
    check($sformatf("byte_present[%0d]", k), 32'(cap.size() != 0), 32'h1);
    if (cap.size() != 0) begin
      e = cap.pop_front();
      check($sformatf("byte[%0d]", k), 32'(e), 32'({2'(k), l, d}));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      clear[k] = 1'b0; in_valid[k] = 1'b0; in_data[k] = 4'h0; out_ready[k] = 1'b1;
    end

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid[2]), 32'h0);
    check("rst_in_ready", 32'(in_ready[2]), 32'h1);
    check("rst_busy", 32'(busy[2]), 32'h0);
    check("rst_out_data", 32'(out_data[2]), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // BATCH=4: 3,15,0,7 -> 0x19, 0xF0, valid one cycle after the last sample.
    send(2, 4'd3); send(2, 4'd15); send(2, 4'd0); send(2, 4'd7);
    in_valid[2] = 1'b0;
    @(negedge clk);
    check("lat_out_valid", 32'(out_valid[2]), 32'h1);
    check("lat_out_data", 32'(out_data[2]), 32'h19);
    wait_cycles(4);
    expect_byte(2, 1'b0, 8'h19);
    expect_byte(2, 1'b1, 8'hF0);

    // BATCH=16: sixteen 15s -> 0xF0, 0xFF.
    for (int i = 0; i < 16; i++) send(3, 4'd15);
    in_valid[3] = 1'b0;
    wait_cycles(4);
    expect_byte(3, 1'b0, 8'hF0);
    expect_byte(3, 1'b1, 8'hFF);

    // BATCH=4 with a 5-cycle downstream stall and ignored input pulses.
    out_ready[2] = 1'b0;
    for (int i = 0; i < 4; i++) send(2, 4'd2);
    in_valid[2] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_data", 32'(out_data[2]), 32'h08);
      check("stall_in_ready", 32'(in_ready[2]), 32'h0);
      check("stall_out_valid", 32'(out_valid[2]), 32'h1);
      @(posedge clk); #1;
      in_valid[2] = ~in_valid[2];
      in_data[2]  = 4'd9;
    end
    in_valid[2]  = 1'b0;
    out_ready[2] = 1'b1;
    wait_cycles(4);
    expect_byte(2, 1'b0, 8'h08);
    expect_byte(2, 1'b1, 8'h22);

    // Abort mid-batch, then a clean batch.
    send(2, 4'd5); send(2, 4'd6);
    in_valid[2] = 1'b0;
    clear[2] = 1'b1;
    @(posedge clk); #1;
    clear[2] = 1'b0;
    @(negedge clk);
    check("clear_busy", 32'(busy[2]), 32'h0);
    check("clear_out_valid", 32'(out_valid[2]), 32'h0);
    for (int i = 0; i < 4; i++) send(2, 4'd1);
    in_valid[2] = 1'b0;
    wait_cycles(4);
    expect_byte(2, 1'b0, 8'h04);
    expect_byte(2, 1'b1, 8'h11);
    check("clear_no_extra_bytes", 32'(cap.size()), 32'h0);

    // BATCH=1: reset while the stats byte is pending.
    out_ready[0] = 1'b0;
    send(0, 4'd9);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    expect_byte(0, 1'b0, 8'h09);
    @(negedge clk);
    check("pre_rst_last", 32'(out_last[0]), 32'h1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid[0]), 32'h0);
    check("async_rst_last", 32'(out_last[0]), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready[0] = 1'b1;
    send(0, 4'd9);
    in_valid[0] = 1'b0;
    wait_cycles(4);
    expect_byte(0, 1'b0, 8'h09);
    expect_byte(0, 1'b1, 8'h99);

    // BATCH=2 back-to-back with in_valid held high.
    base = ir_low;
    send(1, 4'd1); send(1, 4'd2); send(1, 4'd3); send(1, 4'd4);
    in_valid[1] = 1'b0;
    wait_cycles(6);
    check("b2b_in_ready_low_cycles", 32'(ir_low - base), 32'd4);
    expect_byte(1, 1'b0, 8'h03);
    expect_byte(1, 1'b1, 8'h21);
    expect_byte(1, 1'b0, 8'h07);
    expect_byte(1, 1'b1, 8'h43);
    check("no_stray_bytes", 32'(cap.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
